// File: rtl/bcd_tod_counter_pkg.sv
// Shared types, digit limits and helper functions for the BCD time-of-day counter.
package bcd_tod_counter_pkg;

    localparam int unsigned MAX_FRAC_DIGITS = 6;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] TENS_MAX     = 4'd5;
    localparam logic [3:0] LEAP_S10     = 4'd6;
    localparam logic [3:0] H10_MAX      = 4'd2;
    localparam logic [3:0] H1_MAX_AT_20 = 4'd3;

    typedef struct packed {
        logic [3:0]                            h10;
        logic [3:0]                            h1;
        logic [3:0]                            m10;
        logic [3:0]                            m1;
        logic [3:0]                            s10;
        logic [3:0]                            s1;
        logic [0:MAX_FRAC_DIGITS-1][3:0]       frac;
    } tod_t;

    typedef enum logic {
        StNormal,
        StLeapSec
    } leap_st_e;

    function automatic logic tod_valid(input tod_t t, input int unsigned n_frac);
        logic ok;
        ok = (t.h10 <= H10_MAX) && (t.h1 <= DIGIT_MAX) && (t.m10 <= TENS_MAX) &&
             (t.m1 <= DIGIT_MAX) && (t.s10 <= TENS_MAX) && (t.s1 <= DIGIT_MAX);
        if ((t.h10 == H10_MAX) && (t.h1 > H1_MAX_AT_20)) ok = 1'b0;
        // Inactive fractional digits are never written, so their load value is irrelevant.
        for (int unsigned i = 0; i < MAX_FRAC_DIGITS; i++) begin
            if ((i < n_frac) && (t.frac[i] > DIGIT_MAX)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [7:0] hour_12h(input logic [3:0] h10, input logic [3:0] h1);
        logic [7:0] r;
        r = {h10, h1};
        if ((h10 == 4'd0) && (h1 == 4'd0)) begin
            r = 8'h12;
        end else if ((h10 == 4'd1) && (h1 >= 4'd3)) begin
            r = {4'd0, h1 - 4'd2};
        end else if (h10 == 4'd2) begin
            r = (h1 <= 4'd1) ? {4'd0, h1 + 4'd8} : {4'd1, h1 - 4'd2};
        end
        return r;
    endfunction

    function automatic logic hour_is_pm(input logic [3:0] h10, input logic [3:0] h1);
        return (h10 == 4'd2) || ((h10 == 4'd1) && (h1 >= 4'd2));
    endfunction

endpackage

// File: rtl/bcd_tod_counter_if.sv
// Control and time/status bundle between a time-of-day counter and its user.
interface bcd_tod_counter_if;
    import bcd_tod_counter_pkg::*;

    logic       tick;
    logic       load;
    tod_t       load_tod;
    logic       leap_arm;
    logic       mode_12h;
    tod_t       tod;
    logic [3:0] disp_h10;
    logic [3:0] disp_h1;
    logic       pm;
    logic       day_wrap;
    logic       leap_done;
    logic       load_err;

    modport master (
        output tick, load, load_tod, leap_arm, mode_12h,
        input  tod, disp_h10, disp_h1, pm, day_wrap, leap_done, load_err
    );

    modport slave (
        input  tick, load, load_tod, leap_arm, mode_12h,
        output tod, disp_h10, disp_h1, pm, day_wrap, leap_done, load_err
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register that counts up to a run-time limit, then wraps to 0 and carries.
module bcd_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic [3:0] i_limit,
    output logic [3:0] o_q,
    output logic [3:0] o_d,
    output logic       o_carry
);

    logic [3:0] r_q;
    logic [3:0] w_d;
    logic       w_at_limit;

    assign w_at_limit = (r_q == i_limit);

    always_comb begin
        w_d = r_q;
        if (i_clr) begin
            w_d = 4'd0;
        end else if (i_load) begin
            w_d = i_load_val;
        end else if (i_inc) begin
            w_d = w_at_limit ? 4'd0 : r_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'd0;
        end else begin
            r_q <= w_d;
        end
    end

    assign o_q     = r_q;
    assign o_d     = w_d;
    assign o_carry = i_inc & w_at_limit;

endmodule

// File: rtl/bcd_tod_counter.sv
// BCD time-of-day counter with sub-second digits, validated load, leap-second insertion
// and a registered 12/24 h hour display.
module bcd_tod_counter
    import bcd_tod_counter_pkg::*;
#(
    parameter int unsigned FRAC_DIGITS = 3,
    parameter int unsigned LEAP_EN     = 1
) (
    input logic              clk,
    input logic              rst_n,
    bcd_tod_counter_if.slave bus
);

    localparam bit LeapOn = (LEAP_EN != 0);

    logic w_tick;
    logic w_load_ok;
    logic w_load_bad;

    assign w_tick     = bus.tick & ~bus.load;
    assign w_load_ok  = bus.load & tod_valid(bus.load_tod, FRAC_DIGITS);
    assign w_load_bad = bus.load & ~w_load_ok;

    leap_st_e r_state;
    leap_st_e w_state_d;
    logic     r_leap_latch;
    logic     w_leap_latch_d;
    logic     w_leap_sec;
    logic     w_leap_ins;
    logic     w_leap_end;

    logic [3:0]                 w_frac_q [MAX_FRAC_DIGITS];
    logic [3:0]                 w_frac_d [MAX_FRAC_DIGITS];
    logic [MAX_FRAC_DIGITS-1:0] w_frac_inc;
    logic [MAX_FRAC_DIGITS-1:0] w_frac_cout;
    logic                       w_sec_inc;
    logic                       unused_frac_cout;

    // Fractional increments look ahead over the register values so no net feeds itself.
    always_comb begin
        logic v_run;
        v_run      = w_tick;
        w_frac_inc = '0;
        for (int i = MAX_FRAC_DIGITS - 1; i >= 0; i--) begin
            if (i < int'(FRAC_DIGITS)) begin
                w_frac_inc[i] = v_run;
                v_run         = v_run & (w_frac_q[i] == DIGIT_MAX);
            end
        end
    end

    for (genvar i = 0; i < MAX_FRAC_DIGITS; i++) begin : g_frac
        if (i < FRAC_DIGITS) begin : g_on
            bcd_digit u_digit (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_inc     (w_frac_inc[i]),
                .i_clr     (1'b0),
                .i_load    (w_load_ok),
                .i_load_val(bus.load_tod.frac[i]),
                .i_limit   (DIGIT_MAX),
                .o_q       (w_frac_q[i]),
                .o_d       (w_frac_d[i]),
                .o_carry   (w_frac_cout[i])
            );
        end else begin : g_off
            assign w_frac_q[i]    = 4'd0;
            assign w_frac_d[i]    = 4'd0;
            assign w_frac_cout[i] = 1'b0;
        end
    end

    // Only the most-significant fractional carry reaches seconds; the others are
    // already folded into w_frac_inc.
    assign w_sec_inc        = (FRAC_DIGITS == 0) ? w_tick : w_frac_cout[0];
    assign unused_frac_cout = ^w_frac_cout[MAX_FRAC_DIGITS-1:1];

    logic [3:0] w_s1_q, w_s10_q, w_m1_q, w_m10_q, w_h1_q, w_h10_q;
    logic [3:0] w_s1_d, w_s10_d, w_m1_d, w_m10_d, w_h1_d, w_h10_d;
    logic       w_s1_carry, w_s10_carry, w_m1_carry, w_m10_carry, w_h1_carry, w_h10_carry;
    logic [3:0] w_s1_lim, w_s10_lim, w_h1_lim;

    assign w_leap_sec = (r_state == StLeapSec);
    assign w_leap_ins = LeapOn && (r_state == StNormal) && (r_leap_latch | bus.leap_arm) &&
                        (w_h10_q == 4'd2) && (w_h1_q == 4'd3) && (w_m10_q == 4'd5) &&
                        (w_m1_q == 4'd9) && (w_s10_q == 4'd5);
    // Second 60 lasts one full second: s1 stays 0 and its carry ends the day.
    assign w_leap_end = w_leap_sec & w_s1_carry;

    assign w_s1_lim  = w_leap_sec ? 4'd0 : DIGIT_MAX;
    assign w_s10_lim = (w_leap_sec | w_leap_ins) ? LEAP_S10 : TENS_MAX;
    assign w_h1_lim  = (w_h10_q == H10_MAX) ? H1_MAX_AT_20 : DIGIT_MAX;

    bcd_digit u_s1 (
        .clk(clk), .rst_n(rst_n), .i_inc(w_sec_inc), .i_clr(w_leap_end), .i_load(w_load_ok),
        .i_load_val(bus.load_tod.s1), .i_limit(w_s1_lim),
        .o_q(w_s1_q), .o_d(w_s1_d), .o_carry(w_s1_carry)
    );
    bcd_digit u_s10 (
        .clk(clk), .rst_n(rst_n), .i_inc(w_s1_carry), .i_clr(w_leap_end), .i_load(w_load_ok),
        .i_load_val(bus.load_tod.s10), .i_limit(w_s10_lim),
        .o_q(w_s10_q), .o_d(w_s10_d), .o_carry(w_s10_carry)
    );
    bcd_digit u_m1 (
        .clk(clk), .rst_n(rst_n), .i_inc(w_s10_carry), .i_clr(w_leap_end), .i_load(w_load_ok),
        .i_load_val(bus.load_tod.m1), .i_limit(DIGIT_MAX),
        .o_q(w_m1_q), .o_d(w_m1_d), .o_carry(w_m1_carry)
    );
    bcd_digit u_m10 (
        .clk(clk), .rst_n(rst_n), .i_inc(w_m1_carry), .i_clr(w_leap_end), .i_load(w_load_ok),
        .i_load_val(bus.load_tod.m10), .i_limit(TENS_MAX),
        .o_q(w_m10_q), .o_d(w_m10_d), .o_carry(w_m10_carry)
    );
    bcd_digit u_h1 (
        .clk(clk), .rst_n(rst_n), .i_inc(w_m10_carry), .i_clr(w_leap_end), .i_load(w_load_ok),
        .i_load_val(bus.load_tod.h1), .i_limit(w_h1_lim),
        .o_q(w_h1_q), .o_d(w_h1_d), .o_carry(w_h1_carry)
    );
    bcd_digit u_h10 (
        .clk(clk), .rst_n(rst_n), .i_inc(w_h1_carry), .i_clr(w_leap_end), .i_load(w_load_ok),
        .i_load_val(bus.load_tod.h10), .i_limit(H10_MAX),
        .o_q(w_h10_q), .o_d(w_h10_d), .o_carry(w_h10_carry)
    );

    tod_t w_q;
    tod_t w_d;

    always_comb begin
        w_q = '{h10: w_h10_q, h1: w_h1_q, m10: w_m10_q, m1: w_m1_q, s10: w_s10_q, s1: w_s1_q,
                frac: '0};
        w_d = '{h10: w_h10_d, h1: w_h1_d, m10: w_m10_d, m1: w_m1_d, s10: w_s10_d, s1: w_s1_d,
                frac: '0};
        for (int i = 0; i < MAX_FRAC_DIGITS; i++) begin
            w_q.frac[i] = w_frac_q[i];
            w_d.frac[i] = w_frac_d[i];
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_leap_latch_d = r_leap_latch;
        unique case (r_state)
            StNormal:  if (w_leap_ins && w_s1_carry) w_state_d = StNormal == StNormal ? StLeapSec : StNormal;
            StLeapSec: if (w_leap_end || w_load_ok) w_state_d = StNormal;
        endcase
        if (bus.load || w_leap_end) begin
            w_leap_latch_d = 1'b0;
        end else if (LeapOn && bus.leap_arm) begin
            w_leap_latch_d = 1'b1;
        end
    end

    logic [7:0] w_disp_d;
    logic [3:0] r_disp_h10, r_disp_h1;
    logic       r_pm, r_day_wrap, r_leap_done, r_load_err;

    assign w_disp_d = bus.mode_12h ? hour_12h(w_d.h10, w_d.h1) : {w_d.h10, w_d.h1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StNormal;
            r_leap_latch <= 1'b0;
            r_disp_h10   <= 4'd0;
            r_disp_h1    <= 4'd0;
            r_pm         <= 1'b0;
            r_day_wrap   <= 1'b0;
            r_leap_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_leap_latch <= w_leap_latch_d;
            r_disp_h10   <= w_disp_d[7:4];
            r_disp_h1    <= w_disp_d[3:0];
            r_pm         <= hour_is_pm(w_d.h10, w_d.h1);
            r_day_wrap   <= w_h10_carry | w_leap_end;
            r_leap_done  <= w_leap_end;
            r_load_err   <= w_load_bad;
        end
    end

    assign bus.tod       = w_q;
    assign bus.disp_h10  = r_disp_h10;
    assign bus.disp_h1   = r_disp_h1;
    assign bus.pm        = r_pm;
    assign bus.day_wrap  = r_day_wrap;
    assign bus.leap_done = r_leap_done;
    assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_tod_counter.sv
// Directed bench for bcd_tod_counter: one 3-digit-fraction instance with leap support
// and one instance without fractional digits.
module tb_bcd_tod_counter;
    import bcd_tod_counter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_tod_counter_if u_if_a ();
    bcd_tod_counter_if u_if_b ();

    bcd_tod_counter #(.FRAC_DIGITS(3), .LEAP_EN(1)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if_a.slave)
    );

    bcd_tod_counter #(.FRAC_DIGITS(0), .LEAP_EN(1)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [47:0] t, input logic with_tick);
        u_if_a.load_tod = t;
        u_if_a.load     = 1'b1;
        u_if_a.tick     = with_tick;
        cycle();
        u_if_a.load = 1'b0;
        u_if_a.tick = 1'b0;
    endtask

    task automatic tick_a(input int n);
        repeat (n) begin
            u_if_a.tick = 1'b1;
            cycle();
        end
        u_if_a.tick = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        u_if_a.tick     = 1'b0;
        u_if_a.load     = 1'b0;
        u_if_a.load_tod = '0;
        u_if_a.leap_arm = 1'b0;
        u_if_a.mode_12h = 1'b0;
        u_if_b.tick     = 1'b0;
        u_if_b.load     = 1'b0;
        u_if_b.load_tod = '0;
        u_if_b.leap_arm = 1'b0;
        u_if_b.mode_12h = 1'b0;
        repeat (2) cycle();

        check("rst_tod", u_if_a.tod, 48'h0);
        check("rst_disp", {40'h0, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h0);
        check("rst_flags", {44'h0, u_if_a.pm, u_if_a.day_wrap, u_if_a.leap_done,
                            u_if_a.load_err}, 48'h0);

        rst_n = 1'b1;
        cycle();
        tick_a(1);
        check("first_tick", u_if_a.tod, 48'h000000_001000);
        tick_a(1);
        check("tick_nocarry", u_if_a.tod, 48'h000000_002000);

        // Plain day rollover
        load_a(48'h235959_999000, 1'b0);
        check("load_2359", u_if_a.tod, 48'h235959_999000);
        check("load_ok_err", {47'h0, u_if_a.load_err}, 48'h0);
        tick_a(1);
        check("wrap_tod", u_if_a.tod, 48'h000000_000000);
        check("wrap_pulse", {47'h0, u_if_a.day_wrap}, 48'h1);
        cycle();
        check("wrap_one_cycle", {47'h0, u_if_a.day_wrap}, 48'h0);

        // Leap second insertion
        u_if_a.leap_arm = 1'b1;
        load_a(48'h235959_999000, 1'b0);
        tick_a(1);
        u_if_a.leap_arm = 1'b0;
        check("leap_60", u_if_a.tod, 48'h235960_000000);
        check("leap_no_wrap", {47'h0, u_if_a.day_wrap}, 48'h0);
        tick_a(999);
        check("leap_999", u_if_a.tod, 48'h235960_999000);
        check("leap_done_early", {47'h0, u_if_a.leap_done}, 48'h0);
        tick_a(1);
        check("leap_end_tod", u_if_a.tod, 48'h000000_000000);
        check("leap_end_flags", {46'h0, u_if_a.day_wrap, u_if_a.leap_done}, 48'h3);
        cycle();
        check("leap_flags_clear", {46'h0, u_if_a.day_wrap, u_if_a.leap_done}, 48'h0);

        // Rejected loads
        load_a(48'h125A00_000000, 1'b0);
        check("bad_min_err", {47'h0, u_if_a.load_err}, 48'h1);
        check("bad_min_tod", u_if_a.tod, 48'h000000_000000);
        cycle();
        check("err_one_cycle", {47'h0, u_if_a.load_err}, 48'h0);
        load_a(48'h240000_000000, 1'b0);
        check("bad_hour_err", {47'h0, u_if_a.load_err}, 48'h1);
        check("bad_hour_tod", u_if_a.tod, 48'h000000_000000);

        // 12 h display
        u_if_a.mode_12h = 1'b1;
        load_a(48'h003000_000000, 1'b0);
        check("h12_0030", {39'h0, u_if_a.pm, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h012);
        load_a(48'h120000_000000, 1'b0);
        check("h12_1200", {39'h0, u_if_a.pm, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h112);
        load_a(48'h130500_000000, 1'b0);
        check("h12_1305", {39'h0, u_if_a.pm, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h101);
        load_a(48'h230000_000000, 1'b0);
        check("h12_2300", {39'h0, u_if_a.pm, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h111);
        u_if_a.mode_12h = 1'b0;
        load_a(48'h130500_000000, 1'b0);
        check("h24_1305", {39'h0, u_if_a.pm, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h113);

        // Load beats a simultaneous tick
        load_a(48'h010000_000000, 1'b1);
        check("load_wins", u_if_a.tod, 48'h010000_000000);

        // No fractional digits: tick drives seconds directly
        u_if_b.load_tod = 48'h000059_000000;
        u_if_b.load     = 1'b1;
        cycle();
        u_if_b.load = 1'b0;
        check("nofrac_load", u_if_b.tod, 48'h000059_000000);
        u_if_b.tick = 1'b1;
        cycle();
        check("nofrac_carry", u_if_b.tod, 48'h000100_000000);
        cycle();
        u_if_b.tick = 1'b0;
        check("nofrac_tick", u_if_b.tod, 48'h000101_000000);

        // Asynchronous reset in the middle of a tick stream
        load_a(48'h102030_456000, 1'b0);
        u_if_a.tick = 1'b1;
        repeat (3) cycle();
        check("stream_tod", u_if_a.tod, 48'h102030_459000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_tod", u_if_a.tod, 48'h0);
        check("async_rst_disp", {40'h0, u_if_a.disp_h10, u_if_a.disp_h1}, 48'h0);
        check("async_rst_flags", {44'h0, u_if_a.pm, u_if_a.day_wrap, u_if_a.leap_done,
                                  u_if_a.load_err}, 48'h0);
        u_if_a.tick = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        tick_a(1);
        check("post_rst_tick", u_if_a.tod, 48'h000000_001000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
